// File: rtl/toggle_activity_counter.sv
// Per-signal toggle counter over a programmable window; counts drain over valid/ready.
// Define TOGGLE_SUM_EN to add the toggle_sum output (sum of all drained counts).

module toggle_activity_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             sig,
  output logic [CNT_W-1:0] cnt_d
);
  logic             prev;
  logic [CNT_W-1:0] cnt;

  // cnt_d is the post-compare value this cycle; equals cnt whenever en is low
  always_comb begin
    cnt_d = cnt;
    if (en && (sig ^ prev) && (cnt != '1)) cnt_d = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      prev <= sig;
      cnt  <= '0;
    end else begin
      if (en) prev <= sig;
      cnt <= cnt_d;
    end
  end
endmodule

module toggle_activity_counter #(
  parameter int NSIG  = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [WIN_W-1:0]                     win_len,
  input  logic [NSIG-1:0]                      sig_in,
  output logic                                 busy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [((NSIG>1)?$clog2(NSIG):1)-1:0] out_idx,
  output logic [CNT_W-1:0]                     out_count,
  output logic                                 done
`ifdef TOGGLE_SUM_EN
  ,
  output logic [CNT_W+$clog2(NSIG):0]          toggle_sum
`endif
);
  localparam int IDX_W = (NSIG > 1) ? $clog2(NSIG) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN, FIN} state_t;
  state_t state_q, state_d;

  logic [WIN_W-1:0]            cyc, wl;
  logic [NSIG-1:0][CNT_W-1:0]  cnt_d;
  logic                        lane_load, lane_en, last_cyc, last_idx, xfer;
  logic [IDX_W-1:0]            idx_inc;

  assign lane_load = (state_q == IDLE) && start;
  assign lane_en   = (state_q == COUNT);
  assign last_cyc  = (cyc == wl - WIN_W'(1));
  assign last_idx  = (out_idx == IDX_W'(NSIG-1));
  assign xfer      = out_valid && out_ready;
  assign idx_inc   = out_idx + 1'b1;

  for (genvar i = 0; i < NSIG; i++) begin : g_lane
    toggle_activity_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load),
      .en    (lane_en),
      .sig   (sig_in[i]),
      .cnt_d (cnt_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (win_len == '0) ? DRAIN : COUNT;
      COUNT:   if (last_cyc) state_d = DRAIN;
      DRAIN:   if (xfer && last_idx) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded one cycle ahead so nothing downstream sees a comb path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_count <= '0;
      done      <= 1'b0;
      cyc       <= '0;
      wl        <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy <= 1'b1;
          cyc  <= '0;
          wl   <= win_len;
          if (win_len == '0) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_count <= '0;
          end
        end
        COUNT: begin
          cyc <= cyc + 1'b1;
          if (last_cyc) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_count <= cnt_d[0];
          end
        end
        DRAIN: if (xfer) begin
          if (last_idx) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            out_idx   <= idx_inc;
            out_count <= cnt_d[idx_inc];
          end
        end
        FIN:     busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef TOGGLE_SUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           toggle_sum <= '0;
    else if (lane_load)                   toggle_sum <= '0;
    else if (state_q == DRAIN && xfer)    toggle_sum <= toggle_sum + (CNT_W+$clog2(NSIG)+1)'(out_count);
  end
`endif
endmodule

// File: tb/tb_toggle_activity_counter.sv
// Randomized bench for toggle_activity_counter against a history-based reference model.
module tb_toggle_activity_counter;
  localparam int NSIG  = 4;
  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int IDX_W = 2;
  localparam int SUM_W = CNT_W + $clog2(NSIG) + 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0, rst_n = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [NSIG-1:0]  sig_in = '0;
  logic             busy, out_valid, done;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] out_count;
`ifdef TOGGLE_SUM_EN
  logic [SUM_W-1:0] toggle_sum;
`endif

  int checks = 0, failures = 0;
  int bi[$], bc[$];

  always #5 clk = ~clk;

  toggle_activity_counter #(.NSIG(NSIG), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_len   (win_len),
    .sig_in    (sig_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_count (out_count),
    .done      (done)
`ifdef TOGGLE_SUM_EN
    ,
    .toggle_sum(toggle_sum)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keep the raw sample history of a window, derive counts at its end
  bit              e_busy, e_valid, e_done;
  int              e_idx, e_count, e_sum, m_left;
  int              m_cnt[NSIG];
  logic [NSIG-1:0] m_hist[$];

  task automatic model_reset();
    e_busy = 0; e_valid = 0; e_done = 0;
    e_idx = 0; e_count = 0; e_sum = 0; m_left = 0;
    m_hist.delete();
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  task automatic model_tally_and_drain();
    for (int i = 0; i < NSIG; i++) begin
      int n = 0;
      for (int j = 1; j < m_hist.size(); j++)
        if (m_hist[j][i] != m_hist[j-1][i]) n++;
      m_cnt[i] = (n > MAXC) ? MAXC : n;
    end
    e_valid = 1; e_idx = 0; e_count = m_cnt[0];
  endtask

  task automatic model_step();
    if (e_done) begin
      e_done = 0; e_busy = 0;
    end else if (!e_busy) begin
      if (start) begin
        e_busy = 1; e_sum = 0; m_left = int'(win_len);
        m_hist.delete();
        m_hist.push_back(sig_in);
        if (m_left == 0) model_tally_and_drain();
      end
    end else if (e_valid) begin
      if (out_ready) begin
        e_sum += m_cnt[e_idx];
        if (e_idx == NSIG-1) begin
          e_valid = 0; e_done = 1;
        end else begin
          e_idx++; e_count = m_cnt[e_idx];
        end
      end
    end else begin
      m_hist.push_back(sig_in);
      m_left--;
      if (m_left == 0) model_tally_and_drain();
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy", busy, e_busy);
        chk("out_valid", out_valid, e_valid);
        chk("done", done, e_done);
        if (e_valid) begin
          chk("out_idx", out_idx, e_idx);
          chk("out_count", out_count, e_count);
        end
`ifdef TOGGLE_SUM_EN
        chk("toggle_sum", toggle_sum, e_sum);
`endif
        if (out_valid && out_ready) begin
          bi.push_back(int'(out_idx));
          bc.push_back(int'(out_count));
        end
      end
    end
  end

  function automatic logic [NSIG-1:0] pat(input int mode, input int j);
    logic [NSIG-1:0] v;
    case (mode)
      0: begin v[0] = j[0]; v[1] = j[1]; v[2] = 1'b0; v[3] = (j >= 3); end
      1: v = NSIG'($urandom);
      default: v = j[0] ? '1 : '0;
    endcase
    return v;
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 hold ready low 3 cycles while idx 1 is offered
  task automatic run_window(input int wl, input int mode, input int rdy_mode, input bit poke);
    int j, stall, cyc;
    j = 0; stall = 0; cyc = 0;
    bi.delete(); bc.delete();
    @(posedge clk); #1;
    start = 1'b1; win_len = WIN_W'(wl); sig_in = pat(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      j++;
      sig_in = pat(mode, j);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        default: begin
          if (out_valid && out_idx == 2'd1 && stall < 3) begin out_ready = 1'b0; stall++; end
          else out_ready = 1'b1;
        end
      endcase
      if (poke) start = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc > 400) begin
        checks++; failures++;
        $display("FAIL window_timeout: got no done after %0d cycles, expected done", cyc);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
  endtask

  task automatic run_latency(input int wl, output int lat);
    int cyc;
    cyc = 0;
    bi.delete(); bc.delete();
    @(posedge clk); #1;
    start = 1'b1; win_len = WIN_W'(wl); sig_in = NSIG'($urandom); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
`ifdef TOGGLE_SUM_EN
      if (lat == 1) chk("sum_cleared_on_start", toggle_sum, 0);
`endif
      if (out_valid || lat > 300) break;
    end
    forever begin
      if (done || cyc > 300) break;
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL latency_drain_timeout: got no done, expected done");
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int exp_t2[4] = '{8, 4, 0, 1};
  int lat;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_count", out_count, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // T2 basic pattern
    run_window(8, 0, 0, 0);
    for (int i = 0; i < NSIG; i++) chk("t2_model_cnt", m_cnt[i], exp_t2[i]);
    chk("t2_beats", bi.size(), 4);
    for (int k = 0; k < bi.size(); k++) begin
      chk("t2_idx", bi[k], k);
      chk("t2_count", bc[k], exp_t2[k]);
    end
`ifdef TOGGLE_SUM_EN
    chk("t6_sum_13", toggle_sum, 13);
`endif

    // T4 zero window, and latency for a nonzero window
    run_latency(0, lat);
    chk("t4_latency_wl0", lat, 1);
    chk("t4_beats", bc.size(), 4);
    foreach (bc[k]) chk("t4_count_zero", bc[k], 0);
    run_latency(5, lat);
    chk("latency_wl5", lat, 6);

    // T3 backpressure on idx 1
    run_window(8, 1, 2, 0);
    chk("t3_beats", bi.size(), 4);
    for (int k = 0; k < bi.size(); k++) begin
      chk("t3_idx", bi[k], k);
      chk("t3_count", bc[k], m_cnt[k]);
    end

    // T5 saturation with random backpressure and start pulses while busy
    run_window(40, 2, 1, 1);
    chk("t5_beats", bc.size(), 4);
    foreach (bc[k]) chk("t5_saturated", bc[k], MAXC);

    // Randomized windows
    for (int n = 0; n < 12; n++)
      run_window($urandom_range(0, 40), 1, 1, 1'($urandom));

    // T1 async reset mid-COUNT
    @(posedge clk); #1;
    start = 1'b1; win_len = WIN_W'(20);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t1_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Normal window after the abort
    run_window(6, 1, 1, 0);
    chk("post_reset_beats", bi.size(), 4);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
